// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: state codes, lamp codes, default phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_MG     = 3'd0,
    ST_MY     = 3'd1,
    ST_SG     = 3'd2,
    ST_SG_EXT = 3'd3,
    ST_SY     = 3'd4,
    ST_WALK   = 3'd5
  } state_t;

  // Lamp vectors are {red, yellow, green}.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int unsigned DEF_BASE_TIME = 6;
  localparam int unsigned DEF_EXT_TIME  = 3;
  localparam int unsigned DEF_YEL_TIME  = 2;

endpackage

// File: rtl/traffic_light_fsm.sv
// Main/side-street light sequencer with pedestrian walk phase; drives an external interval timer.
// Every output is a register or a pure decode of the state register, so inputs never reach outputs combinationally.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned BASE_TIME = DEF_BASE_TIME,
  parameter int unsigned EXT_TIME  = DEF_EXT_TIME,
  parameter int unsigned YEL_TIME  = DEF_YEL_TIME
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       expired,
  output logic [3:0] value_out,
  output logic       start_timer,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  localparam logic [3:0] BASE_DUR = 4'(BASE_TIME);
  localparam logic [3:0] EXT_DUR  = 4'(EXT_TIME);
  localparam logic [3:0] YEL_DUR  = 4'(YEL_TIME);

  state_t     state;
  state_t     state_nxt;
  logic       need_start;
  logic       armed;
  logic       start_dly;
  logic       walk_pending;
  logic       issue;
  logic       enter_walk;
  logic [3:0] dur_nxt;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (need_start) begin
      issue     = 1'b1;
      state_nxt = ST_MG;
    end else if (expired && armed) begin
      // Every accepted expiry restarts the timer, including the MG re-arm.
      issue = 1'b1;
      case (state)
        ST_MG:     state_nxt = (sensor || walk_pending) ? ST_MY : ST_MG;
        ST_MY:     state_nxt = ST_SG;
        ST_SG:     state_nxt = sensor ? ST_SG_EXT : ST_SY;
        ST_SG_EXT: state_nxt = ST_SY;
        ST_SY:     state_nxt = walk_pending ? ST_WALK : ST_MG;
        ST_WALK:   state_nxt = ST_MG;
        default:   state_nxt = ST_MG;
      endcase
    end
    enter_walk = issue && (state_nxt == ST_WALK);
  end

  always_comb begin
    dur_nxt = BASE_DUR;
    case (state_nxt)
      ST_MG, ST_SG:        dur_nxt = BASE_DUR;
      ST_MY, ST_SY:        dur_nxt = YEL_DUR;
      ST_SG_EXT, ST_WALK:  dur_nxt = EXT_DUR;
      default:             dur_nxt = BASE_DUR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_MG;
      need_start   <= 1'b1;
      armed        <= 1'b0;
      start_dly    <= 1'b0;
      start_timer  <= 1'b0;
      value_out    <= 4'd0;
      walk_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      need_start   <= 1'b0;
      start_timer  <= issue;
      start_dly    <= start_timer;
      // Two-cycle blind window after each start lets the timer drop a stale expiry.
      armed        <= issue ? 1'b0 : (armed || start_dly);
      if (issue) begin
        value_out <= dur_nxt;
      end
      walk_pending <= walk_request || (walk_pending && !enter_walk);
    end
  end

  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    walk       = 1'b0;
    case (state)
      ST_MG:     main_light = LIGHT_GRN;
      ST_MY:     main_light = LIGHT_YEL;
      ST_SG:     side_light = LIGHT_GRN;
      ST_SG_EXT: side_light = LIGHT_GRN;
      ST_SY:     side_light = LIGHT_YEL;
      ST_WALK:   walk       = 1'b1;
      default:   main_light = LIGHT_RED;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: directed phase walks plus randomized traffic against a cycle-age model.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic [3:0] value_out;
  logic       start_timer;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  always #10 clk = ~clk;

  traffic_light_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .sensor       (sensor),
    .walk_request (walk_request),
    .expired      (expired),
    .value_out    (value_out),
    .start_timer  (start_timer),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk         (walk)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phases indexed in sequence order; durations and lamps come straight from the phase table.
  localparam int P_MG = 0, P_MY = 1, P_SG = 2, P_SGX = 3, P_SY = 4, P_WALK = 5;
  int         dur_tab  [6] = '{6, 2, 6, 3, 2, 3};
  logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100};

  int m_phase, m_age, m_val, m_nxt;
  bit m_need, m_start, m_pend, m_go;
  bit model_ok = 1'b0;

  // m_age counts cycles since the last start (0 in the start cycle); expiry is honoured from age 2.
  always @(posedge clk) begin
    if (reset) begin
      m_phase  = P_MG;
      m_need   = 1'b1;
      m_start  = 1'b0;
      m_val    = 0;
      m_pend   = 1'b0;
      m_age    = -1000;
      model_ok = 1'b1;
    end else begin
      m_go  = 1'b0;
      m_nxt = m_phase;
      if (m_need) begin
        m_go   = 1'b1;
        m_nxt  = P_MG;
        m_need = 1'b0;
      end else if (expired && m_age >= 2) begin
        m_go = 1'b1;
        case (m_phase)
          P_MG:    m_nxt = (sensor || m_pend) ? P_MY : P_MG;
          P_MY:    m_nxt = P_SG;
          P_SG:    m_nxt = sensor ? P_SGX : P_SY;
          P_SGX:   m_nxt = P_SY;
          P_SY:    m_nxt = m_pend ? P_WALK : P_MG;
          default: m_nxt = P_MG;
        endcase
      end
      m_pend = walk_request || (m_pend && !(m_go && m_nxt == P_WALK));
      if (m_go) begin
        m_phase = m_nxt;
        m_start = 1'b1;
        m_val   = dur_tab[m_nxt];
        m_age   = 0;
      end else begin
        m_start = 1'b0;
        if (m_age < 1000) m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("start_timer", 32'(start_timer), 32'(m_start));
      chk("value_out",   32'(value_out),   32'(m_val));
      chk("main_light",  32'(main_light),  32'(main_tab[m_phase]));
      chk("side_light",  32'(side_light),  32'(side_tab[m_phase]));
      chk("walk",        32'(walk),        32'(m_phase == P_WALK));
    end
  end

  // Called at the negedge of a start cycle; raises expired for one cycle once the FSM is armed.
  task automatic pulse_exp(input int n);
    repeat (n) @(negedge clk);
    expired = 1'b1;
    @(negedge clk);
    expired = 1'b0;
  endtask

  task automatic expect_phase(input string tag, input logic [2:0] ml, input logic [2:0] sl,
                              input logic [3:0] v, input logic w);
    chk({tag, ".start"}, 32'(start_timer), 32'd1);
    chk({tag, ".value"}, 32'(value_out),   32'(v));
    chk({tag, ".main"},  32'(main_light),  32'(ml));
    chk({tag, ".side"},  32'(side_light),  32'(sl));
    chk({tag, ".walk"},  32'(walk),        32'(w));
  endtask

  bit hold;

  initial begin
    reset = 1'b1; sensor = 1'b0; walk_request = 1'b0; expired = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.main",  32'(main_light),  32'b001);
    chk("rst.side",  32'(side_light),  32'b100);
    chk("rst.walk",  32'(walk),        32'd0);
    chk("rst.start", 32'(start_timer), 32'd0);
    chk("rst.value", 32'(value_out),   32'd0);
    reset = 1'b0;
    @(negedge clk);
    expect_phase("rst_start", 3'b001, 3'b100, 4'd6, 1'b0);

    pulse_exp(5);
    expect_phase("idle_rearm", 3'b001, 3'b100, 4'd6, 1'b0);

    sensor = 1'b1;
    pulse_exp(2); expect_phase("seq_my",  3'b010, 3'b100, 4'd2, 1'b0);
    pulse_exp(2); expect_phase("seq_sg",  3'b100, 3'b001, 4'd6, 1'b0);
    pulse_exp(2); expect_phase("seq_sgx", 3'b100, 3'b001, 4'd3, 1'b0);
    pulse_exp(2); expect_phase("seq_sy",  3'b100, 3'b010, 4'd2, 1'b0);
    sensor = 1'b0;
    pulse_exp(2); expect_phase("seq_mg",  3'b001, 3'b100, 4'd6, 1'b0);

    walk_request = 1'b1;
    @(negedge clk);
    walk_request = 1'b0;
    pulse_exp(1); expect_phase("wlk_my",   3'b010, 3'b100, 4'd2, 1'b0);
    pulse_exp(2); expect_phase("wlk_sg",   3'b100, 3'b001, 4'd6, 1'b0);
    pulse_exp(2); expect_phase("wlk_sy",   3'b100, 3'b010, 4'd2, 1'b0);
    pulse_exp(2); expect_phase("wlk_walk", 3'b100, 3'b100, 4'd3, 1'b1);
    pulse_exp(2); expect_phase("wlk_mg",   3'b001, 3'b100, 4'd6, 1'b0);
    pulse_exp(2); expect_phase("wlk_clr",  3'b001, 3'b100, 4'd6, 1'b0);

    // expired held high from the start cycle: only the third cycle may transition.
    sensor  = 1'b1;
    expired = 1'b1;
    @(negedge clk);
    chk("tied.t1.start", 32'(start_timer), 32'd0);
    chk("tied.t1.main",  32'(main_light),  32'b001);
    @(negedge clk);
    chk("tied.t2.main",  32'(main_light),  32'b001);
    @(negedge clk);
    expect_phase("tied_my", 3'b010, 3'b100, 4'd2, 1'b0);
    repeat (3) @(negedge clk);
    expect_phase("tied_sg", 3'b100, 3'b001, 4'd6, 1'b0);
    expired = 1'b0;

    walk_request = 1'b1;
    @(negedge clk);
    walk_request = 1'b0;
    pulse_exp(1); expect_phase("rx_sgx", 3'b100, 3'b001, 4'd3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rx.main",  32'(main_light),  32'b001);
    chk("rx.side",  32'(side_light),  32'b100);
    chk("rx.start", 32'(start_timer), 32'd0);
    chk("rx.value", 32'(value_out),   32'd0);
    reset  = 1'b0;
    sensor = 1'b0;
    @(negedge clk);
    expect_phase("rx_start", 3'b001, 3'b100, 4'd6, 1'b0);
    pulse_exp(2); expect_phase("rx_nopend", 3'b001, 3'b100, 4'd6, 1'b0);

    hold = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) hold = !hold;
      reset        = ($urandom_range(0, 299) == 0);
      sensor       = ($urandom_range(0, 3) == 0);
      walk_request = ($urandom_range(0, 19) == 0);
      expired      = hold || ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    reset = 1'b0; expired = 1'b0; sensor = 1'b0; walk_request = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
